pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 3, register-address width.
REQ-002 SHALL have parameter OPC_W, default 5, opcode width.
REQ-003 SHALL have parameter NUM_SRC, default 2, source operands per instruction (1..4).
REQ-004 SHALL have parameter LD_STALL_CYC, default 1, load-use stall length in cycles (1..7).
REQ-005 SHALL have parameter BR_FLUSH_CYC, default 2, taken-branch flush length in cycles (1..7).
REQ-006 SHALL have parameter R0_ZERO, default 0; when 1, address 0 never hazards or forwards.
REQ-007 SHALL have ports, in order: clk in 1, single clock; rst in 1, asynchronous active-high reset.
REQ-008 SHALL have opcode_E in OPC_W, Execute opcode; rd_E in RA_W; reg_write_E in 1.
REQ-009 SHALL have src_D in NUM_SRC*RA_W, Decode sources (source i at bits [i*RA_W +: RA_W]); src_E in NUM_SRC*RA_W, Execute sources, same packing.
REQ-010 SHALL have rd_W in RA_W and reg_write_W in 1, Writeback destination and write enable.
REQ-011 SHALL have branch_taken in 1, branch resolved taken in Execute.
REQ-012 SHALL have outputs stall_F, stall_D, flush_F, flush_D, flush_E, each 1 bit.
REQ-013 SHALL have forward_sel out 2*NUM_SRC (2 bits per source) and busy out 1 (state != IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, LD_STALL, BR_FLUSH with a 3-bit down-counter cnt.
REQ-015 SHALL register rd_W/reg_write_W one cycle into rd_L/wr_L (late-writeback copy).
REQ-016 SHALL set forward_sel[i] = 10 if reg_write_W and rd_W==src_E[i]; else 01 if wr_L and rd_L==src_E[i]; else 00 (W beats late copy), purely combinational.
REQ-017 SHALL define ld_haz = opcode_E in {LBH, LBL} and reg_write_E and rd_E equals any src_D[i].
REQ-018 In IDLE, branch_taken SHALL assert flush_F=flush_D=1 that cycle; if BR_FLUSH_CYC>1, enter BR_FLUSH with cnt=BR_FLUSH_CYC-2.
REQ-019 In IDLE without branch_taken, ld_haz SHALL assert stall_F=stall_D=flush_E=1 that cycle; if LD_STALL_CYC>1, enter LD_STALL with cnt=LD_STALL_CYC-2.
REQ-020 In LD_STALL/BR_FLUSH, outputs SHALL hold that state's pattern; cnt==0 returns to IDLE next edge, else cnt decrements.
REQ-021 branch_taken in LD_STALL SHALL abort the stall, drive the branch pattern that cycle, and reload per REQ-018 (branch priority).
REQ-022 branch_taken in BR_FLUSH SHALL restart the flush (reload cnt); ld_haz SHALL be ignored outside IDLE.
REQ-023 With R0_ZERO=1, comparisons against address 0 SHALL evaluate false in REQ-016/REQ-017.
REQ-024 All outputs not named for the active condition SHALL be 0; forwarding SHALL operate in every state.

Reset
REQ-025 rst high SHALL immediately force state=IDLE, cnt=0, rd_L=0, wr_L=0, and all outputs 0, including forward_sel and busy.
REQ-026 Reset asserted mid-stall or mid-flush SHALL abandon the sequence; first cycle after release behaves as IDLE.

Structure
REQ-027 Opcode constants (LBH, LBL, SETF, CPLF) and state encodings SHALL live in the shared parameters package; none redefined locally.
REQ-028 Per-source compare-and-select SHALL be sub-module hazard_fwd_cmp, instantiated NUM_SRC times via generate.

Verification
REQ-029 rd_W=3, reg_write_W=1, src_E={3,3}, wr_L=1, rd_L=3 -> forward_sel=1010.
REQ-030 opcode_E=LBH, rd_E=2, reg_write_E=1, src_D={5,2}, LD_STALL_CYC=3 -> stall_F/stall_D/flush_E high exactly 3 cycles, busy high cycles 2-3.
REQ-031 branch_taken pulse, BR_FLUSH_CYC=2 -> flush_F/flush_D high 2 cycles, then IDLE.
REQ-032 branch_taken in 2nd cycle of 3-cycle load stall -> stall drops that cycle, flush_F/flush_D high 2 cycles.
REQ-033 rst pulsed in BR_FLUSH -> all outputs 0 asynchronously; after release no flush without new branch_taken.
REQ-034 R0_ZERO=1, LBL with rd_E=0, src_D={0,0} -> no stall; rd_W=0 -> forward_sel=0000.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller slice.
//   Contents:
//     - opcode constants recognised by the controller (LBH, LBL, SETF, CPLF)
//     - FSM state encoding for the stall/flush sequencer
//     - forwarding select encodings used on forward_sel
//     - width of the sequencing down-counter
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   // Opcode values.  They are kept as plain integers so that each user can
   // size them to its own OPC_W with a cast.  LBH/LBL are the two load forms
   // whose result arrives too late for forwarding into the next instruction.
   localparam int unsigned LBH  = 32'h04;
   localparam int unsigned LBL  = 32'h05;
   localparam int unsigned SETF = 32'h10;
   localparam int unsigned CPLF = 32'h11;

   // Sequencer states.  IDLE is the only state in which a new load-use
   // hazard is recognised; the other two replay a fixed output pattern.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LD_STALL = 2'd1,
      ST_BR_FLUSH = 2'd2
   } hz_state_e;

   // Forwarding select, two bits per source operand.
   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_LATE = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;

   // Width of the down-counter that times multi-cycle stalls and flushes.
   localparam int CNT_W = 3;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_fwd_cmp.sv
// ---------------------------------------------------------------------------
// hazard_fwd_cmp
//   Per-source-operand comparator.  One instance exists for every source
//   operand of an instruction.  It produces the forwarding select for the
//   Execute-stage operand and flags whether the Decode-stage operand reads
//   the register being loaded by the instruction currently in Execute.
//
//   Ports:
//     src_e        in  RA_W  Execute-stage source address for this operand
//     src_d        in  RA_W  Decode-stage source address for this operand
//     rd_w         in  RA_W  Writeback destination address
//     reg_write_w  in  1     Writeback write enable
//     rd_l         in  RA_W  late (one cycle delayed) writeback address
//     wr_l         in  1     late (one cycle delayed) writeback enable
//     rd_e         in  RA_W  Execute-stage destination address
//     fwd_sel      out 2     forwarding select for this operand
//     ld_match     out 1     Decode operand equals Execute destination
// ---------------------------------------------------------------------------
module hazard_fwd_cmp
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RA_W    = 3,
   parameter int R0_ZERO = 0
) (
   input  logic [RA_W-1:0] src_e,
   input  logic [RA_W-1:0] src_d,
   input  logic [RA_W-1:0] rd_w,
   input  logic            reg_write_w,
   input  logic [RA_W-1:0] rd_l,
   input  logic            wr_l,
   input  logic [RA_W-1:0] rd_e,
   output logic [1:0]      fwd_sel,
   output logic            ld_match
);

   logic e_addr_live;
   logic d_addr_live;

   // When register 0 is hard-wired to zero, an operand naming it can never
   // depend on an in-flight write, so it is excluded from every comparison.
   assign e_addr_live = !((R0_ZERO != 0) && (src_e == '0));
   assign d_addr_live = !((R0_ZERO != 0) && (src_d == '0));

   // The Writeback value is newer than the late copy, so it wins when both
   // hold the same address.
   always_comb begin
      fwd_sel = FWD_NONE;
      if (e_addr_live && reg_write_w && (rd_w == src_e)) begin
         fwd_sel = FWD_WB;
      end else if (e_addr_live && wr_l && (rd_l == src_e)) begin
         fwd_sel = FWD_LATE;
      end
   end

   assign ld_match = d_addr_live && (rd_e == src_d);

endmodule : hazard_fwd_cmp

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard controller for a short in-order pipeline.  It resolves
//   read-after-write hazards by forwarding from Writeback or from a one-cycle
//   delayed copy of Writeback, stalls Fetch/Decode behind loads whose data is
//   not yet available, and flushes Fetch/Decode after a taken branch.
//
//   Ports:
//     clk           in  1             clock
//     rst           in  1             asynchronous active-high reset
//     opcode_E      in  OPC_W         opcode of the instruction in Execute
//     rd_E          in  RA_W          destination address in Execute
//     reg_write_E   in  1             Execute instruction writes rd_E
//     src_D         in  NUM_SRC*RA_W  Decode sources, source i at [i*RA_W +: RA_W]
//     src_E         in  NUM_SRC*RA_W  Execute sources, same packing
//     rd_W          in  RA_W          Writeback destination
//     reg_write_W   in  1             Writeback write enable
//     branch_taken  in  1             branch in Execute resolved taken
//     stall_F       out 1             hold Fetch
//     stall_D       out 1             hold Decode
//     flush_F       out 1             squash Fetch
//     flush_D       out 1             squash Decode
//     flush_E       out 1             insert bubble into Execute
//     forward_sel   out 2*NUM_SRC     per-source forwarding select
//     busy          out 1             a multi-cycle stall or flush is running
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RA_W         = 3,
   parameter int OPC_W        = 5,
   parameter int NUM_SRC      = 2,
   parameter int LD_STALL_CYC = 1,
   parameter int BR_FLUSH_CYC = 2,
   parameter int R0_ZERO      = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPC_W-1:0]        opcode_E,
   input  logic [RA_W-1:0]         rd_E,
   input  logic                    reg_write_E,
   input  logic [NUM_SRC*RA_W-1:0] src_D,
   input  logic [NUM_SRC*RA_W-1:0] src_E,
   input  logic [RA_W-1:0]         rd_W,
   input  logic                    reg_write_W,
   input  logic                    branch_taken,
   output logic                    stall_F,
   output logic                    stall_D,
   output logic                    flush_F,
   output logic                    flush_D,
   output logic                    flush_E,
   output logic [2*NUM_SRC-1:0]    forward_sel,
   output logic                    busy
);

   // Counter reload values.  The cycle in which the condition is detected is
   // the first cycle of the sequence, so the counter only covers the
   // remaining cycles and counts down to zero inclusive.
   localparam logic [CNT_W-1:0] LD_RELOAD =
      (LD_STALL_CYC > 1) ? CNT_W'(LD_STALL_CYC - 2) : '0;
   localparam logic [CNT_W-1:0] BR_RELOAD =
      (BR_FLUSH_CYC > 1) ? CNT_W'(BR_FLUSH_CYC - 2) : '0;

   hz_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RA_W-1:0]   rd_l_q, rd_l_d;
   logic              wr_l_q, wr_l_d;

   logic [NUM_SRC-1:0]   src_hit;
   logic [2*NUM_SRC-1:0] fwd_c;
   logic                 is_load;
   logic                 e_dst_live;
   logic                 ld_haz;
   logic                 stall_c;
   logic                 flush_fd_c;
   logic                 flush_e_c;

   // One comparator per source operand handles both the forwarding select
   // for Execute and the load-use match for Decode.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hazard_fwd_cmp #(
         .RA_W    (RA_W),
         .R0_ZERO (R0_ZERO)
      ) u_cmp (
         .src_e       (src_E[i*RA_W +: RA_W]),
         .src_d       (src_D[i*RA_W +: RA_W]),
         .rd_w        (rd_W),
         .reg_write_w (reg_write_W),
         .rd_l        (rd_l_q),
         .wr_l        (wr_l_q),
         .rd_e        (rd_E),
         .fwd_sel     (fwd_c[2*i +: 2]),
         .ld_match    (src_hit[i])
      );
   end

   // A load-use hazard exists when a load in Execute writes a register that
   // the instruction in Decode reads.  A load targeting the hard-wired zero
   // register writes nothing, so it never causes a stall.
   assign is_load    = (opcode_E == OPC_W'(LBH)) || (opcode_E == OPC_W'(LBL));
   assign e_dst_live = !((R0_ZERO != 0) && (rd_E == '0));
   assign ld_haz     = is_load && reg_write_E && e_dst_live && (|src_hit);

   // The late copy simply trails Writeback by one cycle so that a consumer
   // reaching Execute one cycle after the producer retired still sees it.
   always_comb begin
      rd_l_d = rd_W;
      wr_l_d = reg_write_W;
   end

   // Sequencer next-state and output decode.  A taken branch has priority
   // over everything: it aborts a running load stall and restarts a running
   // flush.  New load hazards are only honoured from IDLE because a stall or
   // flush already in progress has frozen or squashed the Decode instruction.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stall_c    = 1'b0;
      flush_fd_c = 1'b0;
      flush_e_c  = 1'b0;

      if (branch_taken) begin
         flush_fd_c = 1'b1;
         if (BR_FLUSH_CYC > 1) begin
            state_d = ST_BR_FLUSH;
            cnt_d   = BR_RELOAD;
         end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ld_haz) begin
                  stall_c   = 1'b1;
                  flush_e_c = 1'b1;
                  if (LD_STALL_CYC > 1) begin
                     state_d = ST_LD_STALL;
                     cnt_d   = LD_RELOAD;
                  end
               end
            end
            ST_LD_STALL: begin
               stall_c   = 1'b1;
               flush_e_c = 1'b1;
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_BR_FLUSH: begin
               flush_fd_c = 1'b1;
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, counter and late-writeback copy.  Reset abandons any running
   // sequence so the first cycle after release is a plain IDLE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rd_l_q  <= '0;
         wr_l_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_l_q  <= rd_l_d;
         wr_l_q  <= wr_l_d;
      end
   end

   // Outputs follow the current cycle's inputs so that a hazard is acted on
   // in the cycle it is seen.  Reset masks them directly because the
   // forwarding path depends on live Writeback inputs, not only on flops.
   assign stall_F     = stall_c    & ~rst;
   assign stall_D     = stall_c    & ~rst;
   assign flush_F     = flush_fd_c & ~rst;
   assign flush_D     = flush_fd_c & ~rst;
   assign flush_E     = flush_e_c  & ~rst;
   assign forward_sel = rst ? '0 : fwd_c;
   assign busy        = (state_q != ST_IDLE) & ~rst;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two controllers share one set of inputs:
//     u_dut_a : LD_STALL_CYC=3, BR_FLUSH_CYC=2, R0_ZERO=0
//     u_dut_z : LD_STALL_CYC=1, BR_FLUSH_CYC=3, R0_ZERO=1
//   A directed vector table and hand sequences cover the listed scenarios,
//   then random traffic is compared against a cycle-count reference model.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   logic       clk;
   logic       rst;
   logic [4:0] opcode_E;
   logic [2:0] rd_E;
   logic       reg_write_E;
   logic [5:0] src_D;
   logic [5:0] src_E;
   logic [2:0] rd_W;
   logic       reg_write_W;
   logic       branch_taken;

   logic       a_stall_F, a_stall_D, a_flush_F, a_flush_D, a_flush_E, a_busy;
   logic [3:0] a_fwd;
   logic       z_stall_F, z_stall_D, z_flush_F, z_flush_D, z_flush_E, z_busy;
   logic [3:0] z_fwd;

   logic [9:0] out_a;
   logic [9:0] out_z;

   int checks;
   int failures;

   // Packed view: {busy, forward_sel, flush_E, flush_D, flush_F, stall_D, stall_F}
   assign out_a = {a_busy, a_fwd, a_flush_E, a_flush_D, a_flush_F, a_stall_D, a_stall_F};
   assign out_z = {z_busy, z_fwd, z_flush_E, z_flush_D, z_flush_F, z_stall_D, z_stall_F};

   pipe_hazard_ctrl #(
      .RA_W(3), .OPC_W(5), .NUM_SRC(2),
      .LD_STALL_CYC(3), .BR_FLUSH_CYC(2), .R0_ZERO(0)
   ) u_dut_a (
      .clk(clk), .rst(rst),
      .opcode_E(opcode_E), .rd_E(rd_E), .reg_write_E(reg_write_E),
      .src_D(src_D), .src_E(src_E),
      .rd_W(rd_W), .reg_write_W(reg_write_W),
      .branch_taken(branch_taken),
      .stall_F(a_stall_F), .stall_D(a_stall_D),
      .flush_F(a_flush_F), .flush_D(a_flush_D), .flush_E(a_flush_E),
      .forward_sel(a_fwd), .busy(a_busy)
   );

   pipe_hazard_ctrl #(
      .RA_W(3), .OPC_W(5), .NUM_SRC(2),
      .LD_STALL_CYC(1), .BR_FLUSH_CYC(3), .R0_ZERO(1)
   ) u_dut_z (
      .clk(clk), .rst(rst),
      .opcode_E(opcode_E), .rd_E(rd_E), .reg_write_E(reg_write_E),
      .src_D(src_D), .src_E(src_E),
      .rd_W(rd_W), .reg_write_W(reg_write_W),
      .branch_taken(branch_taken),
      .stall_F(z_stall_F), .stall_D(z_stall_D),
      .flush_F(z_flush_F), .flush_D(z_flush_D), .flush_E(z_flush_E),
      .forward_sel(z_fwd), .busy(z_busy)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       brt;
      logic [4:0] opc;
      logic [2:0] rd_e;
      logic       we_e;
      logic [5:0] src_d;
      logic [5:0] src_e;
      logic [2:0] rd_w;
      logic       we_w;
      logic       stall;
      logic       flush_fd;
      logic       flush_e;
      logic [3:0] fwd;
      logic       busy;
   } vec_t;

   vec_t tbl[19];

   // Reference model state: cycles still owed by a running sequence and
   // which sequence it is (1 = load stall, 2 = branch flush), plus the
   // previous cycle's Writeback destination.
   int         m_rem[2];
   int         m_mode[2];
   logic [2:0] m_rd_l;
   logic       m_wr_l;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      branch_taken = v.brt;
      opcode_E     = v.opc;
      rd_E         = v.rd_e;
      reg_write_E  = v.we_e;
      src_D        = v.src_d;
      src_E        = v.src_e;
      rd_W         = v.rd_w;
      reg_write_W  = v.we_w;
   endtask

   task automatic clearInputs();
      vec_t v;
      v = '0;
      applyStimulus(v);
   endtask

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Address equality with optional zero-register suppression.
   function automatic logic addrHit(input int r0, input logic [2:0] a, input logic [2:0] b);
      return (a == b) && !((r0 != 0) && (a == 3'd0));
   endfunction

   // Model one cycle of instance k from the current inputs and model state.
   task automatic modelEval(input int k, output logic [9:0] exp, output int nrem, output int nmode);
      int         ldc, brc, r0;
      logic       st, fl, fe, bz, ldh;
      logic [3:0] fw;
      logic [2:0] s;
      ldc   = (k == 0) ? 3 : 1;
      brc   = (k == 0) ? 2 : 3;
      r0    = (k == 0) ? 0 : 1;
      st    = 1'b0; fl = 1'b0; fe = 1'b0; bz = 1'b0; fw = 4'b0;
      nrem  = m_rem[k];
      nmode = m_mode[k];
      if (rst) begin
         nrem  = 0;
         nmode = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            s = src_E[i*3 +: 3];
            if (reg_write_W && addrHit(r0, s, rd_W))   fw[2*i +: 2] = 2'd2;
            else if (m_wr_l && addrHit(r0, s, m_rd_l)) fw[2*i +: 2] = 2'd1;
         end
         ldh = ((opcode_E == 5'(LBH)) || (opcode_E == 5'(LBL))) && reg_write_E &&
               (addrHit(r0, rd_E, src_D[2:0]) || addrHit(r0, rd_E, src_D[5:3]));
         bz = (m_rem[k] > 0);
         if (branch_taken) begin
            fl = 1'b1; nrem = brc - 1; nmode = 2;
         end else if (m_rem[k] > 0) begin
            if (m_mode[k] == 1) begin st = 1'b1; fe = 1'b1; end
            else fl = 1'b1;
            nrem = m_rem[k] - 1;
         end else if (ldh) begin
            st = 1'b1; fe = 1'b1; nrem = ldc - 1; nmode = 1;
         end
      end
      exp = {bz, fw, fe, fl, fl, st, st};
   endtask

   initial begin
      logic [9:0] exp_a, exp_z;
      int         nr_a, nm_a, nr_z, nm_z;
      vec_t       v;

      checks   = 0;
      failures = 0;

      //                 brt opc       rd_e we_e src_d          src_e          rd_w we_w  st fl fe fwd      busy
      tbl[0]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          {3'd3,3'd3}, 3'd3, 1'b1, 1'b0,1'b0,1'b0,4'b1010,1'b0};
      tbl[1]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          {3'd3,3'd3}, 3'd3, 1'b1, 1'b0,1'b0,1'b0,4'b1010,1'b0};
      tbl[2]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          {3'd3,3'd1}, 3'd0, 1'b0, 1'b0,1'b0,1'b0,4'b0100,1'b0};
      tbl[3]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          {3'd0,3'd5}, 3'd5, 1'b1, 1'b0,1'b0,1'b0,4'b0010,1'b0};
      tbl[4]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          {3'd5,3'd2}, 3'd2, 1'b1, 1'b0,1'b0,1'b0,4'b0110,1'b0};
      tbl[5]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          {3'd0,3'd0}, 3'd0, 1'b0, 1'b0,1'b0,1'b0,4'b0000,1'b0};
      tbl[6]  = '{1'b0, 5'(LBH),    3'd2, 1'b1, {3'd5,3'd2},   6'd0,        3'd0, 1'b0, 1'b1,1'b0,1'b1,4'b0000,1'b0};
      tbl[7]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          6'd0,        3'd0, 1'b0, 1'b1,1'b0,1'b1,4'b0000,1'b1};
      tbl[8]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          6'd0,        3'd0, 1'b0, 1'b1,1'b0,1'b1,4'b0000,1'b1};
      tbl[9]  = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          6'd0,        3'd0, 1'b0, 1'b0,1'b0,1'b0,4'b0000,1'b0};
      tbl[10] = '{1'b0, 5'(LBL),    3'd4, 1'b0, {3'd4,3'd4},   6'd0,        3'd0, 1'b0, 1'b0,1'b0,1'b0,4'b0000,1'b0};
      tbl[11] = '{1'b0, 5'(SETF),   3'd4, 1'b1, {3'd4,3'd4},   6'd0,        3'd0, 1'b0, 1'b0,1'b0,1'b0,4'b0000,1'b0};
      tbl[12] = '{1'b0, 5'(LBL),    3'd7, 1'b1, {3'd7,3'd1},   6'd0,        3'd0, 1'b0, 1'b1,1'b0,1'b1,4'b0000,1'b0};
      tbl[13] = '{1'b1, 5'd0,       3'd0, 1'b0, 6'd0,          6'd0,        3'd0, 1'b0, 1'b0,1'b1,1'b0,4'b0000,1'b1};
      tbl[14] = '{1'b0, 5'(LBH),    3'd1, 1'b1, {3'd1,3'd1},   6'd0,        3'd0, 1'b0, 1'b0,1'b1,1'b0,4'b0000,1'b1};
      tbl[15] = '{1'b1, 5'd0,       3'd0, 1'b0, 6'd0,          6'd0,        3'd0, 1'b0, 1'b0,1'b1,1'b0,4'b0000,1'b0};
      tbl[16] = '{1'b1, 5'd0,       3'd0, 1'b0, 6'd0,          6'd0,        3'd0, 1'b0, 1'b0,1'b1,1'b0,4'b0000,1'b1};
      tbl[17] = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          6'd0,        3'd0, 1'b0, 1'b0,1'b1,1'b0,4'b0000,1'b1};
      tbl[18] = '{1'b0, 5'd0,       3'd0, 1'b0, 6'd0,          6'd0,        3'd0, 1'b0, 1'b0,1'b0,1'b0,4'b0000,1'b0};

      // Reset with live Writeback traffic: everything must read zero.
      rst = 1'b1;
      clearInputs();
      reg_write_W = 1'b1; rd_W = 3'd3; src_E = {3'd3, 3'd3};
      branch_taken = 1'b1;
      #2;
      checkOutput("reset_a", 32'(out_a), 32'd0);
      checkOutput("reset_z", 32'(out_z), 32'd0);
      nextCycle();
      clearInputs();
      rst = 1'b0;

      // Directed vector table on instance a.
      for (int n = 0; n < 19; n++) begin
         applyStimulus(tbl[n]);
         #2;
         checkOutput($sformatf("tbl%0d_stall_F", n), 32'(a_stall_F), 32'(tbl[n].stall));
         checkOutput($sformatf("tbl%0d_stall_D", n), 32'(a_stall_D), 32'(tbl[n].stall));
         checkOutput($sformatf("tbl%0d_flush_F", n), 32'(a_flush_F), 32'(tbl[n].flush_fd));
         checkOutput($sformatf("tbl%0d_flush_D", n), 32'(a_flush_D), 32'(tbl[n].flush_fd));
         checkOutput($sformatf("tbl%0d_flush_E", n), 32'(a_flush_E), 32'(tbl[n].flush_e));
         checkOutput($sformatf("tbl%0d_fwd", n),     32'(a_fwd),     32'(tbl[n].fwd));
         checkOutput($sformatf("tbl%0d_busy", n),    32'(a_busy),    32'(tbl[n].busy));
         nextCycle();
      end
      clearInputs();

      // Reset pulsed in the middle of a branch flush.
      branch_taken = 1'b1;
      #2;
      checkOutput("rstflush_first", 32'(out_a), 32'b0_0000_0_1_1_0_0);
      nextCycle();
      branch_taken = 1'b0;
      reg_write_W = 1'b1; rd_W = 3'd3; src_E = {3'd3, 3'd3};
      #2;
      checkOutput("rstflush_mid", 32'(out_a), 32'b1_1010_0_1_1_0_0);
      rst = 1'b1;
      #1;
      checkOutput("rstflush_async_a", 32'(out_a), 32'd0);
      checkOutput("rstflush_async_z", 32'(out_z), 32'd0);
      nextCycle();
      rst = 1'b0;
      clearInputs();
      #2;
      checkOutput("rstflush_after0", 32'(out_a), 32'd0);
      nextCycle();
      #2;
      checkOutput("rstflush_after1", 32'(out_a), 32'd0);
      nextCycle();

      // Zero register on the R0_ZERO instance, contrasted with instance a.
      opcode_E = 5'(LBL); rd_E = 3'd0; reg_write_E = 1'b1; src_D = {3'd0, 3'd0};
      reg_write_W = 1'b1; rd_W = 3'd0; src_E = {3'd0, 3'd0};
      #2;
      checkOutput("r0_z_nostall", 32'(z_stall_F), 32'd0);
      checkOutput("r0_z_fwd_wb", 32'(z_fwd), 32'd0);
      checkOutput("r0_a_stall", 32'(a_stall_D), 32'd1);
      checkOutput("r0_a_fwd_wb", 32'(a_fwd), 32'b1010);
      nextCycle();
      clearInputs();
      #2;
      checkOutput("r0_z_fwd_late", 32'(z_fwd), 32'd0);
      checkOutput("r0_a_fwd_late", 32'(a_fwd), 32'b0101);
      nextCycle();

      // Single-cycle load stall on instance z: no busy, ends at once.
      opcode_E = 5'(LBH); rd_E = 3'd1; reg_write_E = 1'b1; src_D = {3'd0, 3'd1};
      #2;
      checkOutput("z_ld1_stall", 32'(out_z), 32'b0_0000_1_0_0_1_1);
      nextCycle();
      clearInputs();
      #2;
      checkOutput("z_ld1_after", 32'(out_z), 32'd0);

      // Start random traffic from a known state.
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_rem[k]  = 0;
         m_mode[k] = 0;
      end
      m_rd_l = 3'd0;
      m_wr_l = 1'b0;
      nextCycle();
      rst = 1'b0;

      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 3))
            0: v.opc = 5'(LBH);
            1: v.opc = 5'(LBL);
            2: v.opc = 5'(SETF);
            default: v.opc = 5'($urandom_range(0, 31));
         endcase
         v.brt   = ($urandom_range(0, 9) == 0);
         v.rd_e  = 3'($urandom_range(0, 3));
         v.we_e  = 1'($urandom_range(0, 1));
         v.src_d = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
         v.src_e = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
         v.rd_w  = 3'($urandom_range(0, 3));
         v.we_w  = 1'($urandom_range(0, 1));
         applyStimulus(v);
         rst = ($urandom_range(0, 59) == 0);
         #2;
         modelEval(0, exp_a, nr_a, nm_a);
         modelEval(1, exp_z, nr_z, nm_z);
         checkOutput($sformatf("rand%0d_a", n), 32'(out_a), 32'(exp_a));
         checkOutput($sformatf("rand%0d_z", n), 32'(out_z), 32'(exp_z));
         @(posedge clk);
         m_rem[0] = nr_a; m_mode[0] = nm_a;
         m_rem[1] = nr_z; m_mode[1] = nm_z;
         m_rd_l = rst ? 3'd0 : rd_W;
         m_wr_l = rst ? 1'b0 : reg_write_W;
         #1;
         rst = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
